mipi_csi_rx_raw_depacker_8b4lane: RTL and testbench

Converts the stripped 4-lane CSI-2 payload stream (32 bits/cycle at MIPI byte clock) into unpacked pixels, four per output beat. Sits directly downstream of the packet decoder and consumes its data, valid, packet-length and packet-type outputs. It supports RAW10, RAW12 and RAW14 packets. Trailing bytes beyond the packet length are discarded, and malformed lines are flagged.

---
 rtl/mipi_csi_pkg.sv | 40 ++++
 rtl/mipi_csi_raw_unpack_4px.sv | 42 ++++
 rtl/mipi_csi_rx_raw_depacker_8b4lane.sv | 151 +++++++++++++++
 tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 RAW depacker: lane geometry, data-type codes,
// per-type group sizes and the receive FSM encoding.
// No ports; imported by the depacker top and the pixel unpacker.
package mipi_csi_pkg;

  localparam int MIPI_GEAR  = 8;   // bits per lane per byte-clock cycle
  localparam int LANES      = 4;   // lane count
  localparam int PIXEL_SLOT = 16;  // output bits per pixel slot
  localparam int BUF_BYTES  = 10;  // worst case: 6 leftover RAW14 bytes + 4 new

  // Low three bits of the CSI-2 data ID for the supported RAW formats.
  localparam logic [2:0] TYPE_RAW10 = 3'd3;
  localparam logic [2:0] TYPE_RAW12 = 3'd4;
  localparam logic [2:0] TYPE_RAW14 = 3'd5;

  // Bytes carrying one group of four pixels.
  localparam logic [3:0] GRP_RAW10 = 4'd5;
  localparam logic [3:0] GRP_RAW12 = 4'd6;
  localparam logic [3:0] GRP_RAW14 = 4'd7;

  // ST_SYNC waits for a low valid so a packet cut by reset is not picked up mid-way.
  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_ACTIVE
  } rx_state_e;

  // Group size for a data type; zero marks an unsupported type.
  function automatic logic [3:0] group_size(input logic [2:0] pkt_type);
    logic [3:0] g;
    case (pkt_type)
      TYPE_RAW10: g = GRP_RAW10;
      TYPE_RAW12: g = GRP_RAW12;
      TYPE_RAW14: g = GRP_RAW14;
      default:    g = 4'd0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mipi_csi_raw_unpack_4px.sv
// Combinational unpacker: turns the lowest bytes of a RAW10/12/14 group into four
// right-justified 16-bit pixels. Ports: type_i (data type code), bytes_i (7 bytes,
// byte0 at [7:0]), pixels_o (P0 at [15:0] .. P3 at [63:48]); zero for other types.
module mipi_csi_raw_unpack_4px
  import mipi_csi_pkg::*;
(
  input  logic [2:0]                type_i,
  input  logic [55:0]               bytes_i,
  output logic [4*PIXEL_SLOT-1:0]   pixels_o
);

  logic [7:0]  b [7];
  logic [23:0] low14;

  always_comb begin
    for (int i = 0; i < 7; i++) b[i] = bytes_i[8*i +: 8];
    // RAW14 low bits form one little-endian 24-bit field, 6 bits per pixel.
    low14 = {b[6], b[5], b[4]};
  end

  always_comb begin
    pixels_o = '0;
    case (type_i)
      TYPE_RAW10: begin
        for (int i = 0; i < 4; i++)
          pixels_o[16*i +: 16] = {6'd0, b[i], b[4][2*i +: 2]};
      end
      TYPE_RAW12: begin
        pixels_o[15:0]  = {4'd0, b[0], b[2][3:0]};
        pixels_o[31:16] = {4'd0, b[1], b[2][7:4]};
        pixels_o[47:32] = {4'd0, b[3], b[5][3:0]};
        pixels_o[63:48] = {4'd0, b[4], b[5][7:4]};
      end
      TYPE_RAW14: begin
        for (int i = 0; i < 4; i++)
          pixels_o[16*i +: 16] = {2'd0, b[i], low14[6*i +: 6]};
      end
      default: pixels_o = '0;
    endcase
  end

endmodule

// File: rtl/mipi_csi_rx_raw_depacker_8b4lane.sv
// CSI-2 4-lane RAW10/12/14 depacker: accumulates payload bytes, emits four pixels
// per beat one clock after the completing word, and flags malformed lines.
// Ports: clk_i/reset_n_i; data_valid_i, data_i, packet_length_i, packet_type_i in;
// pixel_valid_o, pixel_data_o, line_done_o, line_err_o out (all registered).
module mipi_csi_rx_raw_depacker_8b4lane
  import mipi_csi_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        data_valid_i,
  input  logic [LANES*MIPI_GEAR-1:0]  data_i,
  input  logic [15:0]                 packet_length_i,
  input  logic [2:0]                  packet_type_i,
  output logic                        pixel_valid_o,
  output logic [4*PIXEL_SLOT-1:0]     pixel_data_o,
  output logic                        line_done_o,
  output logic                        line_err_o
);

  localparam int BUF_W = BUF_BYTES * 8;

  rx_state_e             state_q, state_d;
  logic [2:0]            type_q, type_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [3:0]            fill_q, fill_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic                  pix_vld_q, pix_vld_d;
  logic [63:0]           pix_dat_q, pix_dat_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Append path, valid for the current cycle's word.
  logic                  take;
  logic [2:0]            cur_type;
  logic [15:0]           cur_rem;
  logic [2:0]            n_take;
  logic [3:0]            grp;
  logic [31:0]           data_masked;
  logic [BUF_W-1:0]      buf_app;
  logic [3:0]            fill_app;
  logic [63:0]           unpacked;

  always_comb begin
    take     = 1'b0;
    cur_type = type_q;
    cur_rem  = remaining_q;
    // The start cycle uses the live type/length since the latches are not yet loaded.
    if (data_valid_i && state_q == ST_IDLE) begin
      take     = 1'b1;
      cur_type = packet_type_i;
      cur_rem  = packet_length_i;
    end else if (data_valid_i && state_q == ST_ACTIVE) begin
      take     = 1'b1;
    end
    n_take = (cur_rem >= 16'd4) ? 3'd4 : cur_rem[2:0];
    grp    = group_size(cur_type);
    // Bytes past the packet length are zeroed so the buffer above fill stays clean.
    data_masked = '0;
    for (int k = 0; k < 4; k++)
      data_masked[8*k +: 8] = (3'(k) < n_take) ? data_i[8*k +: 8] : 8'h00;
    buf_app  = buf_q | ({{(BUF_W-32){1'b0}}, data_masked} << {fill_q, 3'b000});
    fill_app = fill_q + {1'b0, n_take};
  end

  mipi_csi_raw_unpack_4px u_unpack (
    .type_i   (cur_type),
    .bytes_i  (buf_app[55:0]),
    .pixels_o (unpacked)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    remaining_d = remaining_q;
    fill_d      = fill_q;
    buf_d       = buf_q;
    pix_vld_d   = 1'b0;
    pix_dat_d   = pix_dat_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (data_valid_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!data_valid_i) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          err_d       = (fill_q != 4'd0) || (remaining_q != 16'd0) ||
                        (group_size(type_q) == 4'd0);
          type_d      = '0;
          remaining_d = '0;
          fill_d      = '0;
          buf_d       = '0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (take) begin
      type_d      = cur_type;
      remaining_d = cur_rem - {13'd0, n_take};
      // Unsupported types keep the buffer empty: the packet is dropped whole.
      if (grp != 4'd0) begin
        if (fill_app >= grp) begin
          pix_vld_d = 1'b1;
          pix_dat_d = unpacked;
          buf_d     = buf_app >> {grp, 3'b000};
          fill_d    = fill_app - grp;
        end else begin
          buf_d     = buf_app;
          fill_d    = fill_app;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_SYNC;
      type_q      <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      buf_q       <= '0;
      pix_vld_q   <= 1'b0;
      pix_dat_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
      buf_q       <= buf_d;
      pix_vld_q   <= pix_vld_d;
      pix_dat_q   <= pix_dat_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign pixel_valid_o = pix_vld_q;
  assign pixel_data_o  = pix_dat_q;
  assign line_done_o   = done_q;
  assign line_err_o    = err_q;

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv
// Scoreboard bench for the CSI-2 RAW depacker: directed and randomized packets,
// expectations from a byte-level reference model, monitor compares on each beat.
// Ports: none (top-level bench).
module tb_mipi_csi_rx_raw_depacker_8b4lane;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic [15:0] packet_length_i;
  logic [2:0]  packet_type_i;
  logic        pixel_valid_o;
  logic [63:0] pixel_data_o;
  logic        line_done_o;
  logic        line_err_o;

  always #5 clk_i = ~clk_i;

  mipi_csi_rx_raw_depacker_8b4lane dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .packet_length_i (packet_length_i),
    .packet_type_i   (packet_type_i),
    .pixel_valid_o   (pixel_valid_o),
    .pixel_data_o    (pixel_data_o),
    .line_done_o     (line_done_o),
    .line_err_o      (line_err_o)
  );

  logic [63:0] exp_pix_q[$];
  bit          exp_err_q[$];
  logic [31:0] pkt_words[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int cyc      = 0;
  int beat_cnt = 0;
  int last_pix_cyc  = 0;
  int last_done_cyc = 0;
  int last_word_cyc = 0;
  logic [63:0] last_pix = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference unpack: pixel i is its high byte followed by the low bits drawn
  // from the trailing byte(s) of the group.
  function automatic logic [63:0] model_unpack(input int t, input logic [55:0] g);
    logic [63:0] res;
    int b [7];
    int p;
    int lo;
    res = '0;
    for (int k = 0; k < 7; k++) b[k] = int'(g[8*k +: 8]);
    for (int i = 0; i < 4; i++) begin
      p = 0;
      if (t == 3) begin
        p = b[i] * 4 + ((b[4] >> (2 * i)) & 3);
      end else if (t == 4) begin
        // Two 3-byte pairs: two high bytes then a shared nibble byte.
        p = b[3 * (i / 2) + (i % 2)] * 16 + ((b[3 * (i / 2) + 2] >> (4 * (i % 2))) & 15);
      end else if (t == 5) begin
        lo = b[4] + b[5] * 256 + b[6] * 65536;
        p  = b[i] * 64 + ((lo >> (6 * i)) & 63);
      end
      res[16*i +: 16] = 16'(p);
    end
    return res;
  endfunction

  task automatic model_packet(input int t, input int len, input int nwords);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [55:0] g;
    int avail, nb, gs;
    avail = 4 * nwords;
    nb    = (len < avail) ? len : avail;
    for (int k = 0; k < nb; k++) begin
      w = pkt_words[k / 4];
      bytes.push_back(w[8 * (k % 4) +: 8]);
    end
    gs = (t == 3) ? 5 : (t == 4) ? 6 : (t == 5) ? 7 : 0;
    if (gs != 0) begin
      for (int grpi = 0; grpi < nb / gs; grpi++) begin
        g = '0;
        for (int k = 0; k < gs; k++) g[8*k +: 8] = bytes[grpi * gs + k];
        exp_pix_q.push_back(model_unpack(t, g));
      end
    end
    exp_err_q.push_back((gs == 0) || (len > avail) || ((gs != 0) && (nb % gs != 0)));
  endtask

  task automatic idle(input int n);
    data_valid_i = 1'b0;
    data_i       = $urandom;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [2:0] t, input int len, input bit use_model, input bit scramble);
    int nw;
    nw = pkt_words.size();
    if (use_model) model_packet(int'(t), len, nw);
    for (int i = 0; i < nw; i++) begin
      data_valid_i = 1'b1;
      data_i       = pkt_words[i];
      if (i == 0) begin
        packet_type_i   = t;
        packet_length_i = 16'(len);
      end else if (scramble) begin
        packet_type_i   = 3'($urandom_range(0, 7));
        packet_length_i = 16'($urandom);
      end
      @(posedge clk_i);
      #1;
      last_word_cyc = cyc;
    end
    idle(1);
  endtask

  task automatic rand_words(input int n);
    pkt_words.delete();
    for (int i = 0; i < n; i++) pkt_words.push_back($urandom);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or line end.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      last_pix = '0;
    end else if (mon_en) begin
      if (pixel_valid_o) begin
        beat_cnt++;
        last_pix_cyc = cyc;
        if (exp_pix_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat (cycle %0d)", pixel_data_o, cyc);
        end else begin
          check("pixels", pixel_data_o, exp_pix_q.pop_front());
        end
        last_pix = pixel_data_o;
      end else begin
        check("pixel_hold", pixel_data_o, last_pix);
      end
      if (line_done_o) begin
        last_done_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_line_done: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          check("line_err", 64'(line_err_o), 64'(exp_err_q.pop_front()));
        end
      end else if (line_err_o) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_without_done: got 1, expected 0 (cycle %0d)", cyc);
      end
    end else if (pixel_valid_o) begin
      last_pix = pixel_data_o;
    end
  end

  initial begin
    int b0, t, len, nw, guard;
    int types [8] = '{3, 4, 5, 3, 4, 5, 2, 7};

    reset_n_i       = 1'b0;
    data_valid_i    = 1'b0;
    data_i          = '0;
    packet_length_i = '0;
    packet_type_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_pixel_valid", 64'(pixel_valid_o), 64'd0);
    check("reset_pixel_data",  pixel_data_o,       64'd0);
    check("reset_line_done",   64'(line_done_o),   64'd0);
    check("reset_line_err",    64'(line_err_o),    64'd0);
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    idle(2);

    // RAW10 single group with hand-derived pixels and latency check.
    pkt_words = '{32'hDDCCBBAA, 32'h000000E4};
    exp_pix_q.push_back({16'h0377, 16'h0332, 16'h02ED, 16'h02A8});
    exp_err_q.push_back(1'b0);
    send_pkt(3'd3, 5, 1'b0, 1'b0);
    idle(1);
    check("raw10_latency", 64'(last_pix_cyc), 64'(last_word_cyc));
    check("raw10_done_gap", 64'(last_done_cyc - last_pix_cyc), 64'd1);

    // RAW12 single group, one-cycle gap only.
    pkt_words = '{32'h78563412, 32'h0000BC9A};
    exp_pix_q.push_back({16'h09AB, 16'h078C, 16'h0345, 16'h0126});
    exp_err_q.push_back(1'b0);
    send_pkt(3'd4, 6, 1'b0, 1'b0);

    // RAW14 single group.
    pkt_words = '{32'h018000FF, 32'h000FC03F};
    send_pkt(3'd5, 7, 1'b1, 1'b0);
    idle(1);

    // Long RAW10 line: 640 bytes in 160 words, mid-packet type/length noise.
    rand_words(160);
    b0 = beat_cnt;
    send_pkt(3'd3, 640, 1'b1, 1'b1);
    idle(2);
    check("raw10_640_beats", 64'(beat_cnt - b0), 64'd128);
    check("raw10_640_latency", 64'(last_pix_cyc), 64'(last_word_cyc));
    check("raw10_640_done_gap", 64'(last_done_cyc - last_pix_cyc), 64'd1);

    // RAW10 length 7: one group plus residue, error expected.
    pkt_words = '{32'h44332211, 32'h00556655};
    send_pkt(3'd3, 7, 1'b1, 1'b0);
    // Unsupported type: no pixels, error expected.
    rand_words(3);
    send_pkt(3'd2, 12, 1'b1, 1'b0);
    // Length beyond supplied words: remaining non-zero at end.
    rand_words(2);
    send_pkt(3'd4, 12, 1'b1, 1'b0);
    idle(1);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      t   = types[$urandom_range(0, 7)];
      len = $urandom_range(1, 60);
      nw  = (len + 3) / 4 + $urandom_range(0, 2) - 1;
      if (nw < 1) nw = 1;
      rand_words(nw);
      send_pkt(3'(t), len, 1'b1, $urandom_range(0, 1) == 1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset mid-packet: outputs clear at once; the cut packet is ignored until
    // valid drops and rises again.
    mon_en = 1'b0;
    data_valid_i    = 1'b1;
    packet_type_i   = 3'd3;
    packet_length_i = 16'd40;
    for (int i = 0; i < 3; i++) begin
      data_i = $urandom | 32'h01010101;
      @(posedge clk_i);
      #1;
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    check("midreset_pixel_valid", 64'(pixel_valid_o), 64'd0);
    check("midreset_pixel_data",  pixel_data_o,       64'd0);
    check("midreset_line_done",   64'(line_done_o),   64'd0);
    check("midreset_line_err",    64'(line_err_o),    64'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = $urandom;
      @(posedge clk_i);
      #1;
    end
    idle(1);
    rand_words(6);
    send_pkt(3'd4, 24, 1'b1, 1'b0);
    idle(3);

    guard = 0;
    while ((exp_pix_q.size() != 0 || exp_err_q.size() != 0) && guard < 200) begin
      @(posedge clk_i);
      guard++;
    end
    n_checks++;
    if (exp_pix_q.size() != 0 || exp_err_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats and %0d line ends outstanding, expected 0",
               exp_pix_q.size(), exp_err_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
